fifo_wr_arb: RTL and testbench



---
 rtl/fifo_wr_arb_pkg.sv | 14 +
 rtl/fifo_wr_arb_rr_pick.sv | 31 +++
 rtl/fifo_wr_arb.sv | 100 ++++++++++
 tb/tb_fifo_wr_arb.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_wr_arb_pkg.sv
// Shared types and default sizing for the FIFO write arbiter.
// Imported by the arbiter top and its round-robin picker.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_MAX_BURST  = 8;

endpackage

// File: rtl/fifo_wr_arb_rr_pick.sv
// Round-robin pick: first set request at or above ptr, with wrap.
// Doubling the request vector turns the wrap into one priority scan.
module rr_pick #(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [ID_WIDTH-1:0] ptr,
  output logic                any,
  output logic [ID_WIDTH-1:0] idx
);

  logic [2*NUM_REQ-1:0] dbl;
  logic [2*NUM_REQ-1:0] mask;
  logic [2*NUM_REQ-1:0] hit;

  always_comb begin
    dbl  = {req, req};
    mask = {(2*NUM_REQ){1'b1}} << ptr;
    hit  = dbl & mask;
    any  = |req;
    idx  = '0;
    // scan downward so the lowest masked position wins
    for (int i = 2*NUM_REQ-1; i >= 0; i--) begin
      if (hit[i]) begin
        idx = ID_WIDTH'(i % NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin burst arbiter sharing one sync FIFO write port.
// Grant held until a last beat or MAX_BURST beats transfer.
module fifo_wr_arb
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MAX_BURST  = DEF_MAX_BURST,
  parameter int ID_WIDTH   = $clog2(NUM_REQ),
  parameter int BEAT_WIDTH = $clog2(MAX_BURST+1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_wen,
  output logic [DATA_WIDTH-1:0]         fifo_wdata,
  output logic                          grant_valid,
  output logic [ID_WIDTH-1:0]           grant_id,
  output logic [BEAT_WIDTH-1:0]         beat_cnt
);

  state_t              state;
  logic [ID_WIDTH-1:0] rr_ptr;
  logic [ID_WIDTH-1:0] nxt_ptr;
  logic [ID_WIDTH-1:0] pick_idx;
  logic                pick_any;
  logic                busy;
  logic                xfer;
  logic                cap_hit;
  logic                burst_end;

  rr_pick #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_pick (
    .req (req_valid),
    .ptr (rr_ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  assign busy        = (state == BURST);
  assign grant_valid = busy;

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = busy && !fifo_full &&
                     (grant_id == ID_WIDTH'(i));
    end
  end

  assign xfer       = req_valid[grant_id] & req_ready[grant_id];
  assign fifo_wen   = xfer;
  assign fifo_wdata = req_data[grant_id*DATA_WIDTH +: DATA_WIDTH];

  assign cap_hit   = (beat_cnt == BEAT_WIDTH'(MAX_BURST-1));
  assign burst_end = xfer & (req_last[grant_id] | cap_hit);

  always_comb begin
    nxt_ptr = grant_id + ID_WIDTH'(1);
    if (grant_id == ID_WIDTH'(NUM_REQ-1)) begin
      nxt_ptr = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      grant_id <= '0;
      beat_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pick_any) begin
            state    <= BURST;
            grant_id <= pick_idx;
            beat_cnt <= '0;
          end
        end
        BURST: begin
          if (burst_end) begin
            state    <= IDLE;
            beat_cnt <= '0;
            rr_ptr   <= nxt_ptr;
          end else if (xfer) begin
            beat_cnt <= beat_cnt + BEAT_WIDTH'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Scoreboard bench for fifo_wr_arb: producer queues drive beats,
// a negedge monitor checks every FIFO write against expectations.
module tb_fifo_wr_arb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_last = '0;
  logic [3:0]  req_ready;
  logic        fifo_full = 1'b0;
  logic        fifo_wen;
  logic [7:0]  fifo_wdata;
  logic        grant_valid;
  logic [1:0]  grant_id;
  logic [3:0]  beat_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  logic [8:0]  pq [4][$];
  logic [3:0]  hold = '0;
  logic [13:0] expq [$];

  always #5 clk = ~clk;

  fifo_wr_arb dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .fifo_full   (fifo_full),
    .fifo_wen    (fifo_wen),
    .fifo_wdata  (fifo_wdata),
    .grant_valid (grant_valid),
    .grant_id    (grant_id),
    .beat_cnt    (beat_cnt)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [13:0] ex(input int id, input int bt,
                                     input int d);
    return {id[1:0], bt[3:0], d[7:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input int p, input int d, input bit last);
    pq[p].push_back({last, d[7:0]});
  endtask

  task automatic wait_idle();
    int  n;
    bit  busy;
    n    = 0;
    busy = 1'b1;
    while (busy && n < 200) begin
      @(negedge clk);
      busy = grant_valid || (req_valid != 4'b0) ||
             (pq[0].size() + pq[1].size() + pq[2].size() +
              pq[3].size() != 0);
      n++;
    end
    chk("idle_reached", {31'b0, busy}, 32'd0);
    tick();
  endtask

  // producer model: present queue heads, pop on accepted beats
  initial begin
    logic [3:0] acc;
    forever begin
      @(negedge clk);
      acc = req_valid & req_ready;
      @(posedge clk);
      #2;
      for (int i = 0; i < 4; i++) begin
        if (acc[i] && pq[i].size() > 0) begin
          void'(pq[i].pop_front());
        end
      end
      for (int i = 0; i < 4; i++) begin
        if (pq[i].size() > 0) begin
          req_valid[i]        = !hold[i];
          req_data[i*8 +: 8]  = pq[i][0][7:0];
          req_last[i]         = pq[i][0][8];
        end else begin
          req_valid[i]        = 1'b0;
          req_data[i*8 +: 8]  = 8'h00;
          req_last[i]         = 1'b0;
        end
      end
    end
  end

  // monitor: every FIFO write must match the next expected beat
  initial begin
    logic [13:0] e;
    forever begin
      @(negedge clk);
      if (fifo_wen) begin
        if (expq.size() == 0) begin
          chk("unexpected_write", {18'b0, grant_id, beat_cnt,
              fifo_wdata}, 32'h3fff);
        end else begin
          e = expq.pop_front();
          chk("wr_id", {30'b0, grant_id}, {30'b0, e[13:12]});
          chk("wr_beat", {28'b0, beat_cnt}, {28'b0, e[11:8]});
          chk("wr_data", {24'b0, fifo_wdata}, {24'b0, e[7:0]});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset values
    tick();
    @(negedge clk);
    chk("rst_gv", {31'b0, grant_valid}, 32'd0);
    chk("rst_id", {30'b0, grant_id}, 32'd0);
    chk("rst_beat", {28'b0, beat_cnt}, 32'd0);
    chk("rst_rdy", {28'b0, req_ready}, 32'd0);
    chk("rst_wen", {31'b0, fifo_wen}, 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // single producer, 3-beat packet
    beat(1, 'hA1, 0); beat(1, 'hA2, 0); beat(1, 'hA3, 1);
    expq.push_back(ex(1, 0, 'hA1));
    expq.push_back(ex(1, 1, 'hA2));
    expq.push_back(ex(1, 2, 'hA3));
    @(negedge clk);
    chk("t1_arb_wen", {31'b0, fifo_wen}, 32'd0);
    chk("t1_arb_gv", {31'b0, grant_valid}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t1_wen", {31'b0, fifo_wen}, 32'd1);
    end
    @(negedge clk);
    chk("t1_done_gv", {31'b0, grant_valid}, 32'd0);
    wait_idle();

    // fairness from rr_ptr=2: order 2,3,0,1,0
    beat(0, 'hB0, 1); beat(0, 'hB4, 1);
    beat(1, 'hB1, 1); beat(2, 'hB2, 1); beat(3, 'hB3, 1);
    expq.push_back(ex(2, 0, 'hB2));
    expq.push_back(ex(3, 0, 'hB3));
    expq.push_back(ex(0, 0, 'hB0));
    expq.push_back(ex(1, 0, 'hB1));
    expq.push_back(ex(0, 0, 'hB4));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("fair_wen", {31'b0, fifo_wen}, i % 2);
    end
    wait_idle();

    // burst cap from rr_ptr=1: p2 x8, p3, p2 x8
    for (int i = 0; i < 16; i++) beat(2, 'hD0 + i, 0);
    beat(3, 'hC3, 1);
    for (int i = 0; i < 8; i++) expq.push_back(ex(2, i, 'hD0 + i));
    expq.push_back(ex(3, 0, 'hC3));
    for (int i = 0; i < 8; i++) expq.push_back(ex(2, i, 'hD8 + i));
    wait_idle();

    // backpressure from rr_ptr=3: p0 wins, full for 3 cycles
    for (int i = 0; i < 5; i++) begin
      beat(0, 'hE0 + i, i == 4);
      expq.push_back(ex(0, i, 'hE0 + i));
    end
    tick(); tick(); tick();
    fifo_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_rdy", {28'b0, req_ready}, 32'd0);
      chk("bp_wen", {31'b0, fifo_wen}, 32'd0);
      chk("bp_beat", {28'b0, beat_cnt}, 32'd2);
      tick();
    end
    fifo_full = 1'b0;
    wait_idle();

    // grantee stall from rr_ptr=1: p1 holds grant, p2 waits
    for (int i = 0; i < 4; i++) begin
      beat(1, 'hF0 + i, i == 3);
      expq.push_back(ex(1, i, 'hF0 + i));
    end
    beat(2, 'h60, 1);
    expq.push_back(ex(2, 0, 'h60));
    tick(); tick(); tick();
    hold[1] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_gv", {31'b0, grant_valid}, 32'd1);
      chk("stall_id", {30'b0, grant_id}, 32'd1);
      chk("stall_rdy", {28'b0, req_ready}, 32'h2);
      chk("stall_wen", {31'b0, fifo_wen}, 32'd0);
      tick();
    end
    hold[1] = 1'b0;
    wait_idle();

    // reset mid-burst from rr_ptr=3: p0 wins, reset after 2 beats
    for (int i = 0; i < 4; i++) beat(0, 'h70 + i, i == 3);
    expq.push_back(ex(0, 0, 'h70));
    expq.push_back(ex(0, 1, 'h71));
    expq.push_back(ex(0, 2, 'h72));
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    pq[0].delete();
    beat(1, 'h91, 1);
    beat(3, 'h93, 1);
    expq.push_back(ex(1, 0, 'h91));
    expq.push_back(ex(3, 0, 'h93));
    @(negedge clk);
    chk("mrst_gv", {31'b0, grant_valid}, 32'd0);
    chk("mrst_id", {30'b0, grant_id}, 32'd0);
    chk("mrst_beat", {28'b0, beat_cnt}, 32'd0);
    chk("mrst_rdy", {28'b0, req_ready}, 32'd0);
    chk("mrst_wen", {31'b0, fifo_wen}, 32'd0);
    wait_idle();

    chk("exp_drained", expq.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
